cdbus_csr_arbiter: RTL and testbench
====================================

# cdbus_csr_arbiter

Round-robin arbiter sharing one `cdbus` CSR port between `N_REQ` host requesters (e.g. a CPU bridge and a test/DMA sequencer). Sits between the hosts and a single `cdbus` instance's `chip_select`/`csr_*` pins. Serialises accesses, issues exactly one read or write strobe per grant, and returns read data with a per-requester acknowledge.

## Interface
- `N_REQ`, 2: number of requesters (2..8).
- `ADDR_W`, 4: CSR address width, matches `cdbus` `csr_address`.
- `DATA_W`, 32: CSR data width.
- `RD_LAT`, 1: cycles from `csr_read` strobe to valid `csr_readdata` (1..4).
- `clk`  in  1  single clock, shared with the `cdbus` instance.
- `reset`  in  1  asynchronous, active-high reset.
- `req_read`  in  N_REQ  per-requester read request, held until `req_ack`.
- `req_write`  in  N_REQ  per-requester write request, held until `req_ack`.
- `req_addr`  in  N_REQ*ADDR_W  flattened addresses, requester i at `[i*ADDR_W +: ADDR_W]`.
- `req_wdata`  in  N_REQ*DATA_W  flattened write data, same packing.
- `req_ack`  out  N_REQ  one-cycle completion pulse, at most one bit set.
- `req_rvalid`  out  1  high with `req_ack` when the completed access was a read.
- `req_rdata`  out  DATA_W  read data, valid while `req_rvalid`; holds last value otherwise.
- `proto_err`  out  1  sticky: a requester asserted read and write together.
- `chip_select`  out  1  to `cdbus` `chip_select`.
- `csr_address`  out  ADDR_W  to `cdbus`.
- `csr_read`  out  1  to `cdbus`, one-cycle strobe.
- `csr_write`  out  1  to `cdbus`, one-cycle strobe.
- `csr_writedata`  out  DATA_W  to `cdbus`.
- `csr_readdata`  in  DATA_W  from `cdbus`.

## Operation
- FSM states: IDLE, ISSUE, RDWAIT, RESP.
- IDLE: pending = `req_read | req_write`. If any pending, pick winner by round-robin starting at `last+1` (mod N_REQ); register index, addr, wdata, op; go ISSUE. Else stay.
- ISSUE (1 cycle): `chip_select`=1, `csr_address`/`csr_writedata` from latched values, `csr_write` or `csr_read`=1. Write: `req_ack[g]`=1 this cycle, `last`<=g, go IDLE. Read: go RDWAIT.
- RDWAIT (RD_LAT cycles, down-counter): `chip_select`=1, strobes 0; on final cycle capture `csr_readdata` into `req_rdata`; go RESP.
- RESP (1 cycle): `req_ack[g]`=1, `req_rvalid`=1, `last`<=g, go IDLE.
- Read and write both set on winner: perform write only, set `proto_err` (cleared only by reset).
- Requests changing/dropping after latch have no effect on the in-flight access.
- Requests sampled only in IDLE; a requester must drop its request on the edge after seeing `req_ack`.

## Timing
- Reset values: all outputs 0, state IDLE, `last`=N_REQ-1 (requester 0 wins first), counter 0.
- Reset mid-operation: access abandoned, no ack issued, strobes drop immediately (async).
- Request high in IDLE cycle t: strobe in t+1.
- Write: `csr_write` and `req_ack` both in t+1; IDLE in t+2; next strobe earliest t+3. 2 cycles/write.
- Read: `csr_read` in t+1, `csr_readdata` sampled at end of cycle t+1+RD_LAT, `req_ack`+`req_rvalid` in t+2+RD_LAT. 3+RD_LAT cycles/read.
- Continuous requests from all: grants strictly rotate 0,1,..,N_REQ-1,0.
- Only one requester ever in flight; never two strobes in consecutive cycles.

## Structure
- Package `cdbus_pkg`: FSM state enum, `CDBUS_ADDR_W`=4, `CDBUS_DATA_W`=32 defaults.
- One sub-module `rr_pick`: combinational round-robin priority picker (pending vector, last index -> valid, winner index); reusable for other shared-resource arbiters.
- Arbiter top holds FSM, latches, RD_LAT counter; no other hierarchy.

## Test plan
- Single write: req 0 writes addr 0x3 data 0x0000_00A5 at t -> `csr_write`=1, `csr_address`=0x3, `csr_writedata`=0xA5, `req_ack`=2'b01 all in t+1.
- Single read, RD_LAT=1: req 1 reads addr 0x0, model returns 0xCDB0_0001 in t+2 -> `req_ack`=2'b10, `req_rvalid`=1, `req_rdata`=0xCDB0_0001 in t+3.
- Fairness: both requesters writing continuously for 8 grants -> grant order 0,1,0,1,0,1,0,1; first grant after reset to 0.
- Illegal op: req 0 asserts read and write to 0x5 -> only `csr_write` strobe, ack in t+1, `proto_err`=1 and stays 1 after further legal accesses.
- Reset mid-read: assert `reset` during RDWAIT -> `chip_select`, strobes, `req_ack` all 0 at once; after release, req 1 read completes normally with requester 0 idle.
- RD_LAT=4 read -> ack exactly 6 cycles after request cycle; `chip_select` high for 5 cycles.

Source files
------------

// File: rtl/cdbus_pkg.sv
// Shared definitions for the cdbus CSR arbiter: default bus widths and the
// arbiter FSM state encoding.
package cdbus_pkg;

    localparam int CDBUS_ADDR_W = 4;
    localparam int CDBUS_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_RDWAIT = 2'd2,
        ST_RESP   = 2'd3
    } arb_state_e;

    // Index width for an N-entry selector; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first pending entry found when
// scanning upward from last+1 (wrapping) wins.
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     pending,
    input  logic [IDX_W-1:0] last,
    output logic             valid,
    output logic [IDX_W-1:0] winner
);

    // rot[k] is the pending bit of the requester k+1 positions after last.
    logic [N-1:0]     rot;
    logic [IDX_W-1:0] rot_idx [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_rot
        logic [IDX_W:0] sum;
        assign sum         = {1'b0, last} + (IDX_W+1)'(gi + 1);
        assign rot_idx[gi] = (sum >= (IDX_W+1)'(N)) ? IDX_W'(sum - (IDX_W+1)'(N))
                                                    : sum[IDX_W-1:0];
        assign rot[gi]     = pending[rot_idx[gi]];
    end

    always_comb begin
        valid  = |pending;
        winner = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                winner = rot_idx[i];
            end
        end
    end

endmodule

// File: rtl/cdbus_csr_arbiter.sv
// Round-robin arbiter sharing one cdbus CSR port between N_REQ hosts; one
// access in flight at a time, one strobe per grant, per-requester ack.
module cdbus_csr_arbiter
    import cdbus_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = CDBUS_ADDR_W,
    parameter int DATA_W = CDBUS_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_read,
    input  logic [N_REQ-1:0]          req_write,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_wdata,
    output logic [N_REQ-1:0]          req_ack,
    output logic                      req_rvalid,
    output logic [DATA_W-1:0]         req_rdata,
    output logic                      proto_err,
    output logic                      chip_select,
    output logic [ADDR_W-1:0]         csr_address,
    output logic                      csr_read,
    output logic                      csr_write,
    output logic [DATA_W-1:0]         csr_writedata,
    input  logic [DATA_W-1:0]         csr_readdata
);

    localparam int IDX_W = idx_width(N_REQ);
    localparam int CNT_W = $clog2(RD_LAT + 1);
    localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(RD_LAT - 1);

    arb_state_e          state_reg, state_next;
    logic [IDX_W-1:0]    grant_reg;
    logic [IDX_W-1:0]    last_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic                is_write_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic [DATA_W-1:0]   rdata_reg;
    logic                proto_err_reg;

    logic [N_REQ-1:0]    pending;
    logic                pick_valid;
    logic [IDX_W-1:0]    pick_winner;
    logic                ack_fire;

    assign pending = req_read | req_write;

    rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .pending (pending),
        .last    (last_reg),
        .valid   (pick_valid),
        .winner  (pick_winner)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (pick_valid) state_next = ST_ISSUE;
            ST_ISSUE:  state_next = is_write_reg ? ST_IDLE : ST_RDWAIT;
            ST_RDWAIT: if (cnt_reg == '0) state_next = ST_RESP;
            ST_RESP:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            grant_reg     <= '0;
            last_reg      <= LAST_INIT;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            is_write_reg  <= 1'b0;
            cnt_reg       <= '0;
            rdata_reg     <= '0;
            proto_err_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant_reg    <= pick_winner;
                        addr_reg     <= req_addr[pick_winner*ADDR_W +: ADDR_W];
                        wdata_reg    <= req_wdata[pick_winner*DATA_W +: DATA_W];
                        // A simultaneous read+write is demoted to a write.
                        is_write_reg <= req_write[pick_winner];
                        if (req_read[pick_winner] && req_write[pick_winner]) begin
                            proto_err_reg <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    cnt_reg <= CNT_LOAD;
                    if (is_write_reg) begin
                        last_reg <= grant_reg;
                    end
                end
                ST_RDWAIT: begin
                    if (cnt_reg == '0) begin
                        rdata_reg <= csr_readdata;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    last_reg <= grant_reg;
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decode straight from registered state so reset clears them at once.
    assign chip_select   = (state_reg == ST_ISSUE) || (state_reg == ST_RDWAIT);
    assign csr_read      = (state_reg == ST_ISSUE) && !is_write_reg;
    assign csr_write     = (state_reg == ST_ISSUE) &&  is_write_reg;
    assign csr_address   = addr_reg;
    assign csr_writedata = wdata_reg;

    assign ack_fire = ((state_reg == ST_ISSUE) && is_write_reg) || (state_reg == ST_RESP);

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ack
        assign req_ack[gi] = ack_fire && (grant_reg == IDX_W'(gi));
    end

    assign req_rvalid = (state_reg == ST_RESP);
    assign req_rdata  = rdata_reg;
    assign proto_err  = proto_err_reg;

endmodule

// File: tb/tb_cdbus_csr_arbiter.sv
// Bench for cdbus_csr_arbiter: cycle-level reference of the arbitration rules
// plus a per-requester response scoreboard, and a second RD_LAT=4 instance.
module tb_cdbus_csr_arbiter;

    localparam int N   = 2;
    localparam int AW  = 4;
    localparam int DW  = 32;
    localparam int RL  = 1;
    localparam int RL4 = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    logic [N-1:0]    req_read  = '0;
    logic [N-1:0]    req_write = '0;
    logic [N*AW-1:0] req_addr  = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    req_ack;
    logic            req_rvalid;
    logic [DW-1:0]   req_rdata;
    logic            proto_err;
    logic            chip_select;
    logic [AW-1:0]   csr_address;
    logic            csr_read;
    logic            csr_write;
    logic [DW-1:0]   csr_writedata;
    logic [DW-1:0]   csr_readdata = '0;

    logic [N-1:0]    l4_req_read  = '0;
    logic [N-1:0]    l4_req_write = '0;
    logic [N*AW-1:0] l4_req_addr  = '0;
    logic [N*DW-1:0] l4_req_wdata = '0;
    logic [N-1:0]    l4_req_ack;
    logic            l4_req_rvalid;
    logic [DW-1:0]   l4_req_rdata;
    logic            l4_proto_err;
    logic            l4_chip_select;
    logic [AW-1:0]   l4_csr_address;
    logic            l4_csr_read;
    logic            l4_csr_write;
    logic [DW-1:0]   l4_csr_writedata;
    logic [DW-1:0]   l4_csr_readdata = '0;

    cdbus_csr_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL)) dut (
        .clk(clk), .reset(reset),
        .req_read(req_read), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ack(req_ack), .req_rvalid(req_rvalid), .req_rdata(req_rdata),
        .proto_err(proto_err), .chip_select(chip_select),
        .csr_address(csr_address), .csr_read(csr_read), .csr_write(csr_write),
        .csr_writedata(csr_writedata), .csr_readdata(csr_readdata)
    );

    cdbus_csr_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL4)) dut_l4 (
        .clk(clk), .reset(reset),
        .req_read(l4_req_read), .req_write(l4_req_write),
        .req_addr(l4_req_addr), .req_wdata(l4_req_wdata),
        .req_ack(l4_req_ack), .req_rvalid(l4_req_rvalid), .req_rdata(l4_req_rdata),
        .proto_err(l4_proto_err), .chip_select(l4_chip_select),
        .csr_address(l4_csr_address), .csr_read(l4_csr_read), .csr_write(l4_csr_write),
        .csr_writedata(l4_csr_writedata), .csr_readdata(l4_csr_readdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behaviour of the attached CSR block: each address reads back a fixed pattern.
    function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
        return 32'hCDB0_0001 ^ ({28'h0, a} << 12);
    endfunction

    // Round-robin rule: scan last+1, last+2, ... modulo N for the first pending.
    function automatic int rr_ref(input int last, input logic [N-1:0] p);
        for (int k = 1; k <= N; k++) begin
            if (p[(last + k) % N]) return (last + k) % N;
        end
        return 0;
    endfunction

    typedef struct {
        bit            is_write;
        logic [AW-1:0] addr;
    } exp_t;

    exp_t sb_q0[$];
    exp_t sb_q1[$];
    exp_t sb_e;
    bit   sb_ok;

    // ------------------------------------------------------------------
    // Cycle-level reference: grants, strobes, acks, held read data.
    // ------------------------------------------------------------------
    int            m_last = N - 1;
    bit            m_active = 1'b0;
    int            m_g, m_strobe, m_ack, c;
    bit            m_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    bit            m_proto = 1'b0;
    logic [DW-1:0] m_hold = '0;
    bit            prev_idle = 1'b1;
    logic [N-1:0]    p_rd = '0, p_wr = '0;
    logic [N*AW-1:0] p_addr = '0;
    logic [N*DW-1:0] p_wdata = '0;
    logic [N-1:0]    e_ack;
    bit              e_cs, e_wr, e_rd, e_rv;
    bit              log_en = 1'b0;
    int              grant_log[$];

    always @(negedge clk) begin
        if (reset) begin
            chk("reset_ctrl_outputs",
                {chip_select, csr_read, csr_write, req_ack, req_rvalid, proto_err}, '0);
            chk("reset_rdata", req_rdata, '0);
            m_active  = 1'b0;
            m_last    = N - 1;
            m_proto   = 1'b0;
            m_hold    = '0;
            prev_idle = 1'b1;
            p_rd      = '0;
            p_wr      = '0;
            sb_q0.delete();
            sb_q1.delete();
            csr_readdata = $urandom;
        end else begin
            c = cyc;
            if (prev_idle && ((p_rd | p_wr) != '0)) begin
                m_g      = rr_ref(m_last, p_rd | p_wr);
                m_wr     = p_wr[m_g];
                m_addr   = p_addr[m_g*AW +: AW];
                m_data   = p_wdata[m_g*DW +: DW];
                if (p_rd[m_g] && p_wr[m_g]) m_proto = 1'b1;
                m_strobe = c;
                m_ack    = m_wr ? c : c + 1 + RL;
                m_active = 1'b1;
            end
            e_cs  = m_active && (c >= m_strobe) && (c <= (m_wr ? m_strobe : m_strobe + RL));
            e_wr  = m_active && (c == m_strobe) && m_wr;
            e_rd  = m_active && (c == m_strobe) && !m_wr;
            e_rv  = m_active && (c == m_ack) && !m_wr;
            e_ack = '0;
            if (m_active && (c == m_ack)) e_ack[m_g] = 1'b1;
            if (e_rv) m_hold = rd_model(m_addr);

            chk("chip_select", chip_select, e_cs);
            chk("csr_write", csr_write, e_wr);
            chk("csr_read", csr_read, e_rd);
            chk("req_ack", req_ack, e_ack);
            chk("req_rvalid", req_rvalid, e_rv);
            chk("req_rdata_hold", req_rdata, m_hold);
            chk("proto_err", proto_err, m_proto);
            if (m_active && (c == m_strobe)) begin
                chk("csr_address", csr_address, m_addr);
                if (m_wr) chk("csr_writedata", csr_writedata, m_data);
            end

            if (m_active && !m_wr && (c == m_strobe + RL)) csr_readdata = rd_model(m_addr);
            else csr_readdata = $urandom;

            prev_idle = !m_active;
            if (m_active && (c == m_ack)) begin
                m_last = m_g;
                if (log_en) grant_log.push_back(m_g);
                m_active = 1'b0;
            end
            p_rd    = req_read;
            p_wr    = req_write;
            p_addr  = req_addr;
            p_wdata = req_wdata;
        end
    end

    // Scoreboard: each ack consumes the oldest outstanding request of that requester.
    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                if (req_ack[i]) begin
                    sb_ok = 1'b0;
                    if (i == 0 && sb_q0.size() > 0) begin sb_e = sb_q0.pop_front(); sb_ok = 1'b1; end
                    if (i == 1 && sb_q1.size() > 0) begin sb_e = sb_q1.pop_front(); sb_ok = 1'b1; end
                    chk("sb_entry_present", sb_ok, 1'b1);
                    if (sb_ok) begin
                        chk("sb_rvalid", req_rvalid, !sb_e.is_write);
                        if (!sb_e.is_write) chk("sb_rdata", req_rdata, rd_model(sb_e.addr));
                        $display("txn req%0d %s addr=0x%0h rdata=0x%08h t=%0t", i,
                                 sb_e.is_write ? "WR" : "RD", sb_e.addr, req_rdata, $time);
                    end
                end
            end
        end
    end

    task automatic do_req(input int i, input bit rd, input bit wr,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        bit   seen;
        seen = 1'b0;
        @(posedge clk); #1;
        req_read[i]  = rd;
        req_write[i] = wr;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
        e.is_write = wr;
        e.addr     = a;
        if (i == 0) sb_q0.push_back(e);
        else        sb_q1.push_back(e);
        for (int k = 0; k < 64 && !seen; k++) begin
            @(negedge clk);
            if (req_ack[i]) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL ack_timeout req%0d: no req_ack, expected one within 64 cycles", i);
        end
        @(posedge clk); #1;
        req_read[i]  = 1'b0;
        req_write[i] = 1'b0;
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic rand_driver(input int i, input int n);
        int gap, op;
        for (int k = 0; k < n; k++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) @(posedge clk);
            op = $urandom_range(0, 15);
            do_req(i, (op < 7) || (op == 15), (op >= 7), AW'($urandom_range(0, 15)), $urandom);
        end
    endtask

    int t0, ack_off, rd_off, cs_cnt, rd_cnt;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", {chip_select, csr_read, csr_write, req_ack, req_rvalid, proto_err}, '0);
        @(posedge clk); #1 reset = 1'b0;

        do_req(0, 1'b0, 1'b1, 4'h3, 32'h0000_00A5);
        do_req(1, 1'b1, 1'b0, 4'h0, 32'h0);

        do_req(0, 1'b1, 1'b1, 4'h5, 32'h5A5A_0005);
        do_req(1, 1'b0, 1'b1, 4'hE, 32'h1234_5678);
        do_req(0, 1'b1, 1'b0, 4'h5, 32'h0);
        @(negedge clk);
        chk("proto_err_sticky", proto_err, 1'b1);

        apply_reset();
        @(negedge clk);
        chk("proto_err_cleared", proto_err, 1'b0);
        log_en = 1'b1;
        fork
            begin for (int k = 0; k < 4; k++) do_req(0, 1'b0, 1'b1, AW'(k), 32'hF000_0000 + k); end
            begin for (int k = 0; k < 4; k++) do_req(1, 1'b0, 1'b1, AW'(k + 8), 32'hE000_0000 + k); end
        join
        log_en = 1'b0;
        chk("fair_grant_count", grant_log.size(), 8);
        for (int k = 0; k < grant_log.size(); k++) chk("fair_grant_order", grant_log[k], k % 2);

        // Abandon a read while it waits for data.
        @(posedge clk); #1;
        req_read[1] = 1'b1;
        req_addr[7:4] = 4'h2;
        @(posedge clk);
        @(posedge clk); #2;
        chk("cs_before_reset", chip_select, 1'b1);
        #1 reset = 1'b1;
        #1;
        chk("async_reset_ctrl", {chip_select, csr_read, csr_write, req_ack}, '0);
        req_read[1] = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        do_req(1, 1'b1, 1'b0, 4'h9, 32'h0);

        fork
            rand_driver(0, 40);
            rand_driver(1, 40);
        join

        // RD_LAT=4 instance: one read from requester 0.
        ack_off = -1; rd_off = -1; cs_cnt = 0; rd_cnt = 0;
        @(posedge clk); #1;
        l4_req_read[0] = 1'b1;
        l4_req_addr[3:0] = 4'h7;
        t0 = cyc;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (l4_chip_select) cs_cnt++;
            if (l4_csr_read) begin rd_cnt++; rd_off = cyc - t0; end
            if (l4_req_ack != '0) begin
                ack_off = cyc - t0;
                chk("l4_ack_vector", l4_req_ack, 2'b01);
                chk("l4_rvalid", l4_req_rvalid, 1'b1);
                chk("l4_rdata", l4_req_rdata, rd_model(4'h7));
                l4_req_read[0] = 1'b0;
            end
            l4_csr_readdata = (cyc - t0 == 5) ? rd_model(4'h7) : $urandom;
        end
        chk("l4_ack_latency", ack_off, 6);
        chk("l4_cs_cycles", cs_cnt, 5);
        chk("l4_read_strobes", rd_cnt, 1);
        chk("l4_read_strobe_cycle", rd_off, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule
